bm4_stream_out: RTL and testbench

Output-side unloader for the 4-lane bitonic merge network. Captures a sorted 4-word vector (one transfer per handshake) and streams it out one word per cycle over a valid/ready interface, lane 1 first. A two-entry ping-pong vector buffer decouples the parallel merge pipeline from the serial consumer. Sustains 1 word/cycle with a continuously ready sink.

---
 rtl/bm4_stream_out.sv | 90 +++++++++
 tb/tb_bm4_stream_out.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bm4_stream_out.sv
// Ping-pong unloader: captures a sorted 4-lane vector and streams it out lane 0 first, one word per beat.
// One-cycle latency from accept to lane 0; in_ready falls when both buffers are held, out words hold under out_ready=0.
module bm4_stream_out #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic [DATA_WIDTH-1:0] in3,
    input  logic [DATA_WIDTH-1:0] in4,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_idx,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready
);

    logic [DATA_WIDTH-1:0] vbuf_q [2][4];

    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic [1:0] word_cnt_q, word_cnt_d;

    logic active;
    logic push;
    logic beat;
    logic pop;

    assign active    = en & ~rst;
    assign in_ready  = active & (count_q != 2'd2);
    assign out_valid = active & (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign beat      = out_valid & out_ready;
    assign pop       = beat & (word_cnt_q == 2'd3);

    assign out_data = out_valid ? vbuf_q[rd_ptr_q][word_cnt_q] : '0;
    assign out_idx  = rst ? 2'd0 : word_cnt_q;
    assign out_last = out_valid & (word_cnt_q == 2'd3);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (beat) begin
            word_cnt_d = word_cnt_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            word_cnt_q <= 2'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Vector storage carries no reset; out_data is gated by out_valid so stale words never leak.
    always_ff @(posedge clk) begin
        if (push) begin
            vbuf_q[wr_ptr_q][0] <= in1;
            vbuf_q[wr_ptr_q][1] <= in2;
            vbuf_q[wr_ptr_q][2] <= in3;
            vbuf_q[wr_ptr_q][3] <= in4;
        end
    end

endmodule

// File: tb/tb_bm4_stream_out.sv
module tb_bm4_stream_out;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [31:0] in1, in2, in3, in4;
    logic        in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_idx;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    // Reference: FIFO of whole vectors (at most two) plus the lane position inside the head vector.
    logic [127:0] vq[$];
    int           pos = 0;

    always #5 clk = ~clk;

    bm4_stream_out #(.DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_valid (in_valid),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .in4      (in4),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive inputs after the falling edge, compare against the model, then advance the model
    // to what the next rising edge should produce.
    task automatic step(input logic r, input logic e, input logic iv,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d,
                        input logic ordy);
        logic        x_rdy, x_vld, x_last, do_push, do_beat;
        logic [31:0] x_data;
        logic [1:0]  x_idx;
        logic [127:0] head;
        @(negedge clk);
        rst = r; en = e; in_valid = iv;
        in1 = a; in2 = b; in3 = c; in4 = d;
        out_ready = ordy;
        #1;
        x_rdy  = e && !r && (vq.size() < 2);
        x_vld  = e && !r && (vq.size() > 0);
        head   = (vq.size() > 0) ? vq[0] : 128'd0;
        x_data = x_vld ? head[pos*32 +: 32] : 32'd0;
        x_idx  = r ? 2'd0 : 2'(pos);
        x_last = x_vld && (pos == 3);
        check_eq("in_ready",  {31'd0, in_ready},  {31'd0, x_rdy});
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, x_vld});
        check_eq("out_data",  out_data,           x_data);
        check_eq("out_idx",   {30'd0, out_idx},   {30'd0, x_idx});
        check_eq("out_last",  {31'd0, out_last},  {31'd0, x_last});
        if (r) begin
            vq.delete();
            pos = 0;
        end else begin
            do_push = iv && x_rdy;
            do_beat = x_vld && ordy;
            if (do_beat) begin
                pos++;
                if (pos == 4) begin
                    void'(vq.pop_front());
                    pos = 0;
                end
            end
            if (do_push) vq.push_back({d, c, b, a});
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, ordy);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in1 = 0; in2 = 0; in3 = 0; in4 = 0;

        // Reset with a vector offered: nothing is accepted or shown.
        step(1'b1, 1'b1, 1'b1, 1, 2, 3, 4, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1, 2, 3, 4, 1'b1);
        idle(1, 1'b1);

        // Single vector, lane order and last flag.
        step(1'b0, 1'b1, 1'b1, 5, 9, 12, 30, 1'b1);
        check_eq("single_lane0", out_data, 32'd0);
        idle(5, 1'b1);

        // Back-to-back vectors four cycles apart, no bubble expected.
        step(1'b0, 1'b1, 1'b1, 1, 2, 3, 4, 1'b1);
        idle(3, 1'b1);
        step(1'b0, 1'b1, 1'b1, 10, 20, 30, 40, 1'b1);
        idle(5, 1'b1);

        // Fill both entries under backpressure, offer a third, then drain with C queued behind.
        step(1'b0, 1'b1, 1'b1, 1, 1, 2, 3, 1'b0);
        step(1'b0, 1'b1, 1'b1, 4, 5, 6, 7, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8, 8, 9, 9, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 8, 8, 9, 9, 1'b1);
        idle(10, 1'b1);

        // Enable freeze mid-vector, then reset mid-vector.
        step(1'b0, 1'b1, 1'b1, 3, 6, 7, 11, 1'b1);
        idle(2, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 99, 99, 99, 99, 1'b1);
        idle(1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 0, 0, 0, 1, 1'b1);
        check_eq("post_rst_idx", {30'd0, out_idx}, 32'd0);
        idle(5, 1'b1);

        // Randomised traffic with occasional enable drops and resets.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 90) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 $urandom, $urandom, $urandom, $urandom,
                 ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
